// File: rtl/reaction_timer.sv
// reaction_timer: pseudo-random pre-stimulus delay, then measures ticks until the button press
//
// Ports:
//   clk           system clock
//   reset         asynchronous active-low reset
//   start         level input; rising edge begins a new round (from idle or a held result)
//   button        level input; rising edge ends the measurement or flags a false start
//   stimulus      high only while measuring
//   reaction_time measured ticks (0 on false start, 255 on timeout)
//   result_valid  high while reaction_time/early/timeout hold a completed result
//   early         button pressed before the stimulus
//   timeout       no press within 255 ticks
//   busy          high while waiting for the stimulus or measuring
module reaction_timer #(
    parameter int TICK_DIV  = 10000,
    parameter int MIN_DELAY = 1000,
    parameter int RAND_BITS = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       button,
    output logic       stimulus,
    output logic [7:0] reaction_time,
    output logic       result_valid,
    output logic       early,
    output logic       timeout,
    output logic       busy
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] DELAY       = 3'd1;
    localparam logic [2:0] MEASURE     = 3'd2;
    localparam logic [2:0] DONE        = 3'd3;
    localparam logic [2:0] FALSE_START = 3'd4;
    localparam int         DW          = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);
    localparam logic [15:0] MIN_D      = 16'(MIN_DELAY);
    localparam logic [15:0] RAND_MASK  = 16'((32'd1 << RAND_BITS) - 32'd1);

    logic [2:0]    state, state_nx;
    logic [15:0]   lfsr, delay_cnt;
    logic [DW-1:0] div;
    logic [7:0]    count;
    logic          start_q, button_q;
    logic          start_edge, btn_edge, tick, lfsr_fb;

    assign start_edge = start & ~start_q;
    assign btn_edge   = button & ~button_q;
    assign tick       = div == DIV_LAST;
    // taps for x^16+x^14+x^13+x^11+1 in right-shifting Fibonacci form
    assign lfsr_fb    = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // DONE and FALSE_START behave like IDLE apart from holding the result
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE, FALSE_START: state_nx = start_edge ? DELAY : state;
            DELAY:   state_nx = btn_edge ? FALSE_START : (tick && delay_cnt == 16'd0) ? MEASURE : DELAY;
            MEASURE: state_nx = (btn_edge || (tick && count == 8'hFF)) ? DONE : MEASURE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lfsr          <= 16'hACE1;
            delay_cnt     <= '0;
            div           <= '0;
            count         <= '0;
            start_q       <= 1'b0;
            button_q      <= 1'b0;
            stimulus      <= 1'b0;
            reaction_time <= '0;
            result_valid  <= 1'b0;
            early         <= 1'b0;
            timeout       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            start_q  <= start;
            button_q <= button;
            lfsr     <= {lfsr_fb, lfsr[15:1]};
            state    <= state_nx;
            busy     <= state_nx == DELAY || state_nx == MEASURE;
            stimulus <= state_nx == MEASURE;
            // any state change restarts the time base so each phase begins on a full tick
            div      <= (tick || state_nx != state) ? '0 : div + DW'(1);
            case (state)
                IDLE, DONE, FALSE_START: begin
                    if (start_edge) begin
                        delay_cnt     <= MIN_D + (lfsr & RAND_MASK);
                        reaction_time <= '0;
                        result_valid  <= 1'b0;
                        early         <= 1'b0;
                        timeout       <= 1'b0;
                    end
                end
                DELAY: begin
                    if (btn_edge) begin
                        early         <= 1'b1;
                        result_valid  <= 1'b1;
                        reaction_time <= '0;
                    end else if (tick) begin
                        if (delay_cnt == 16'd0)
                            count <= '0;
                        else
                            delay_cnt <= delay_cnt - 16'd1;
                    end
                end
                MEASURE: begin
                    // the button beats a coincident tick, so the pre-increment count is kept
                    if (btn_edge) begin
                        reaction_time <= count;
                        result_valid  <= 1'b1;
                    end else if (tick) begin
                        if (count == 8'hFF) begin
                            reaction_time <= 8'hFF;
                            timeout       <= 1'b1;
                            result_valid  <= 1'b1;
                        end else begin
                            count <= count + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
